// File: rtl/cnt_pkg.sv
// Shared types and next-count arithmetic for the parametrised up/down counter.
// Combinational helpers only; no latency and no backpressure.
package cnt_pkg;

  typedef enum logic [1:0] {
    CNT_IDLE = 2'd0,
    CNT_RUN  = 2'd1,
    CNT_DONE = 2'd2
  } cnt_state_t;

  // The helper works on a fixed 32-bit word, so counters are limited to WIDTH <= 32.
  localparam int CNT_FN_W = 32;
  typedef logic [CNT_FN_W-1:0] cnt_word_t;

  // Next count modulo max_val+1 in the selected direction.
  function automatic cnt_word_t cnt_next(input cnt_word_t cur,
                                         input logic      up_dn,
                                         input cnt_word_t max_val);
    cnt_word_t nxt;
    if (up_dn) begin
      nxt = (cur == max_val) ? '0 : cur + 32'd1;
    end else begin
      nxt = (cur == '0) ? max_val : cur - 32'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/cnt_ctrl_fsm.sv
// Run/one-shot control FSM for the counter: IDLE, RUN, DONE.
// State updates one clock after inputs are sampled; no backpressure.
module cnt_ctrl_fsm
  import cnt_pkg::*;
#(
  parameter bit AUTO_START = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       term_step,
  output cnt_state_t state,
  output logic       busy,
  output logic       done
);

  cnt_state_t state_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= AUTO_START ? CNT_RUN : CNT_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CNT_IDLE: begin
        if (start) state_nxt = CNT_RUN;
      end
      CNT_RUN: begin
        // term_step is already masked by stop in the datapath, but stop wins here too.
        if (stop)           state_nxt = CNT_IDLE;
        else if (term_step) state_nxt = CNT_DONE;
      end
      CNT_DONE: begin
        if (clear)      state_nxt = CNT_IDLE;
        else if (start) state_nxt = CNT_RUN;
      end
      default: state_nxt = CNT_IDLE;
    endcase
  end

  assign busy = (state == CNT_RUN);
  assign done = (state == CNT_DONE);

endmodule

// File: rtl/param_up_down_counter.sv
// Parametrised up/down counter with load/clear, wrap or saturate, and one-shot control.
// count/wrap/ovf/state update one clock after sampling, tc is combinational; no backpressure.
module param_up_down_counter
  import cnt_pkg::*;
#(
  parameter int             WIDTH      = 4,
  parameter logic [WIDTH-1:0] MAX_VAL  = '1,
  parameter bit             SATURATE   = 1'b0,
  parameter bit             AUTO_START = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             start,
  input  logic             stop,
  input  logic             one_shot,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  cnt_state_t       state;
  logic             tc_i;
  logic             step;
  logic             term_step;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] load_clamped;
  logic             wrap_q;
  logic             wrap_d;
  logic             ovf_q;
  logic             ovf_d;

  assign tc_i         = up_dn ? (count_q == MAX_VAL) : (count_q == '0);
  assign step         = (state == CNT_RUN) && en && !clear && !load && !stop;
  assign term_step    = step && tc_i && one_shot;
  assign step_val     = WIDTH'(cnt_next(cnt_word_t'(count_q), up_dn, cnt_word_t'(MAX_VAL)));
  assign load_clamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;

  // Priority: clear > load > step > hold. wrap defaults low so it is a single-cycle pulse.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    ovf_d   = ovf_q;
    if (clear) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (load) begin
      count_d = load_clamped;
    end else if (step) begin
      if (!tc_i) begin
        count_d = step_val;
      end else if (!one_shot) begin
        ovf_d = 1'b1;
        if (!SATURATE) begin
          count_d = step_val;
          wrap_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
    end
  end

  cnt_ctrl_fsm #(
    .AUTO_START (AUTO_START)
  ) u_fsm (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .clear     (clear),
    .term_step (term_step),
    .state     (state),
    .busy      (busy),
    .done      (done)
  );

  assign count = count_q;
  assign tc    = tc_i;
  assign wrap  = wrap_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_param_up_down_counter.sv
// Directed bench for param_up_down_counter over legacy, modulo-10, saturating,
// manual-start and modulo-1 configurations sharing one input stimulus.
module tb_param_up_down_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       up_dn = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       one_shot = 1'b0;
  logic       clear = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;

  logic [3:0] leg_count, m9_count, sat_count, os_count, m0_count;
  logic       leg_tc, m9_tc, sat_tc, os_tc, m0_tc;
  logic       leg_wrap, m9_wrap, sat_wrap, os_wrap, m0_wrap;
  logic       leg_ovf, m9_ovf, sat_ovf, os_ovf, m0_ovf;
  logic       leg_busy, m9_busy, sat_busy, os_busy, m0_busy;
  logic       leg_done, m9_done, sat_done, os_done, m0_done;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  param_up_down_counter u_leg (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .start(start), .stop(stop),
    .one_shot(one_shot), .clear(clear), .load(load), .load_val(load_val),
    .count(leg_count), .tc(leg_tc), .wrap(leg_wrap), .ovf(leg_ovf),
    .busy(leg_busy), .done(leg_done)
  );

  param_up_down_counter #(.WIDTH(4), .MAX_VAL(4'd9)) u_m9 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .start(start), .stop(stop),
    .one_shot(one_shot), .clear(clear), .load(load), .load_val(load_val),
    .count(m9_count), .tc(m9_tc), .wrap(m9_wrap), .ovf(m9_ovf),
    .busy(m9_busy), .done(m9_done)
  );

  param_up_down_counter #(.WIDTH(4), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .start(start), .stop(stop),
    .one_shot(one_shot), .clear(clear), .load(load), .load_val(load_val),
    .count(sat_count), .tc(sat_tc), .wrap(sat_wrap), .ovf(sat_ovf),
    .busy(sat_busy), .done(sat_done)
  );

  param_up_down_counter #(.WIDTH(4), .AUTO_START(1'b0)) u_os (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .start(start), .stop(stop),
    .one_shot(one_shot), .clear(clear), .load(load), .load_val(load_val),
    .count(os_count), .tc(os_tc), .wrap(os_wrap), .ovf(os_ovf),
    .busy(os_busy), .done(os_done)
  );

  param_up_down_counter #(.WIDTH(4), .MAX_VAL(4'd0)) u_m0 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .start(start), .stop(stop),
    .one_shot(one_shot), .clear(clear), .load(load), .load_val(load_val),
    .count(m0_count), .tc(m0_tc), .wrap(m0_wrap), .ovf(m0_ovf),
    .busy(m0_busy), .done(m0_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    // Legacy free-running mode, plus modulo-1 instance wrapping every cycle.
    en = 1'b1; up_dn = 1'b1;
    do_reset();
    chk("rst_count", leg_count, 0);
    chk("rst_wrap", leg_wrap, 0);
    chk("rst_ovf", leg_ovf, 0);
    chk("rst_busy_auto", leg_busy, 1);
    chk("rst_done", leg_done, 0);
    chk("rst_busy_manual", os_busy, 0);
    for (int k = 1; k <= 19; k++) begin
      tick();
      chk("leg_count", leg_count, k % 16);
      chk("leg_wrap", leg_wrap, (k == 16) ? 1 : 0);
      chk("leg_ovf", leg_ovf, (k >= 16) ? 1 : 0);
      if (k == 15) chk("leg_tc15", leg_tc, 1);
      chk("m0_count", m0_count, 0);
      chk("m0_wrap", m0_wrap, 1);
    end

    // Modulo 10 counting down from a loaded value.
    en = 1'b0; up_dn = 1'b0;
    do_reset();
    load = 1'b1; load_val = 4'd3;
    tick();
    chk("m9_load3", m9_count, 3);
    load = 1'b0; en = 1'b1;
    tick(); chk("m9_dn1", m9_count, 2);
    tick(); chk("m9_dn2", m9_count, 1);
    tick(); chk("m9_dn3", m9_count, 0);
    chk("m9_tc0", m9_tc, 1);
    chk("m9_wrap_pre", m9_wrap, 0);
    tick(); chk("m9_dn4", m9_count, 9);
    chk("m9_wrap", m9_wrap, 1);
    chk("m9_ovf", m9_ovf, 1);
    tick(); chk("m9_dn5", m9_count, 8);
    chk("m9_wrap_gone", m9_wrap, 0);
    en = 1'b0; load = 1'b1; load_val = 4'd12;
    tick();
    chk("m9_clamp", m9_count, 9);
    chk("m9_tc_dn_at9", m9_tc, 0);
    up_dn = 1'b1;
    #1;
    chk("m9_tc_up_at9", m9_tc, 1);
    load = 1'b0;

    // Saturating counter stops at the top.
    do_reset();
    load = 1'b1; load_val = 4'd13;
    tick();
    load = 1'b0; en = 1'b1;
    tick(); chk("sat_14", sat_count, 14); chk("sat_ovf_14", sat_ovf, 0);
    tick(); chk("sat_15", sat_count, 15); chk("sat_ovf_15", sat_ovf, 0);
    chk("sat_tc", sat_tc, 1);
    tick(); chk("sat_hold1", sat_count, 15); chk("sat_ovf_set", sat_ovf, 1);
    chk("sat_wrap1", sat_wrap, 0);
    tick(); chk("sat_hold2", sat_count, 15); chk("sat_wrap2", sat_wrap, 0);
    clear = 1'b1;
    tick(); chk("sat_clr_count", sat_count, 0); chk("sat_clr_ovf", sat_ovf, 0);
    clear = 1'b0;

    // Manual start, one-shot run to the terminal count.
    en = 1'b0; up_dn = 1'b1; one_shot = 1'b1;
    do_reset();
    chk("os_idle_busy", os_busy, 0);
    chk("os_idle_done", os_done, 0);
    start = 1'b1; en = 1'b1;
    tick();
    chk("os_start_busy", os_busy, 1);
    chk("os_start_count", os_count, 0);
    start = 1'b0;
    for (int k = 1; k <= 15; k++) tick();
    chk("os_at15", os_count, 15);
    chk("os_at15_busy", os_busy, 1);
    chk("os_at15_done", os_done, 0);
    tick();
    chk("os_hold", os_count, 15);
    chk("os_done", os_done, 1);
    chk("os_done_busy", os_busy, 0);
    chk("os_no_wrap", os_wrap, 0);
    chk("os_no_ovf", os_ovf, 0);
    tick();
    chk("os_done_stays", os_done, 1);
    start = 1'b1;
    tick();
    chk("os_restart_busy", os_busy, 1);
    chk("os_restart_count", os_count, 15);
    start = 1'b0;
    tick();
    chk("os_redone", os_done, 1);
    clear = 1'b1;
    tick();
    chk("os_clr_count", os_count, 0);
    chk("os_clr_done", os_done, 0);
    chk("os_clr_busy", os_busy, 0);
    clear = 1'b0; one_shot = 1'b0;

    // Simultaneous controls on the legacy counter.
    en = 1'b1; up_dn = 1'b1;
    do_reset();
    load = 1'b1; load_val = 4'd7;
    tick(); chk("sim_load7", leg_count, 7);
    clear = 1'b1;
    tick(); chk("sim_clr_ld_step", leg_count, 0);
    clear = 1'b0; load_val = 4'd10;
    tick(); chk("sim_ld_step", leg_count, 10);
    load_val = 4'd5;
    tick();
    load = 1'b0; stop = 1'b1;
    tick(); chk("sim_stop_count", leg_count, 5); chk("sim_stop_busy", leg_busy, 0);
    stop = 1'b0;
    tick(); chk("sim_idle_hold", leg_count, 5);
    start = 1'b1;
    tick(); chk("sim_start_count", leg_count, 5); chk("sim_start_busy", leg_busy, 1);
    start = 1'b0;
    tick(); chk("sim_resume", leg_count, 6);

    // Asynchronous reset between clock edges.
    en = 1'b0;
    do_reset();
    load = 1'b1; load_val = 4'd4;
    tick();
    load = 1'b0; en = 1'b1;
    tick(); tick(); tick();
    chk("ar_pre7", leg_count, 7);
    #3 rst = 1'b1;
    #1;
    chk("ar_count", leg_count, 0);
    chk("ar_busy_auto", leg_busy, 1);
    @(posedge clk); #1 rst = 1'b0;
    en = 1'b0; load = 1'b1; load_val = 4'd9;
    tick();
    load = 1'b0; en = 1'b1;
    tick();
    chk("ar_m9_wrap_pre", m9_wrap, 1);
    #3 rst = 1'b1;
    #1;
    chk("ar_m9_wrap", m9_wrap, 0);
    chk("ar_m9_count", m9_count, 0);
    chk("ar_m9_ovf", m9_ovf, 0);
    @(posedge clk); #1 rst = 1'b0;
    en = 1'b0;
    chk("ar_rel_busy_manual", os_busy, 0);
    chk("ar_rel_busy_auto", leg_busy, 1);
    tick();
    chk("ar_rel_wrap", m9_wrap, 0);
    chk("ar_rel_count", leg_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/param_up_down_counter.md
Name: param_up_down_counter

Overview:
- Parametrised counter; generalises the team's free-running 4-bit up counter.
- Adds configurable width and modulus, up/down direction, synchronous load and clear, and a wrap or saturate policy.
- Adds a run/one-shot control FSM with terminal-count, wrap-pulse and sticky-overflow status.
- Used as a timer/event counter in control paths; WIDTH=4, AUTO_START=1, en=1 reproduces the legacy 4-bit free-running behaviour.

Parameters:
- WIDTH, 4: counter width in bits (≥1).
- MAX_VAL, 2**WIDTH-1: top count value; modulus is MAX_VAL+1; must be ≤ 2**WIDTH-1.
- SATURATE, 0: 0 = wrap at the bound, 1 = hold at the bound.
- AUTO_START, 1: 1 = FSM leaves reset in RUN; 0 = FSM leaves reset in IDLE.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- en  in  1  count enable; only effective in RUN.
- up_dn  in  1  1 = count up, 0 = count down.
- start  in  1  pulse; IDLE/DONE -> RUN.
- stop  in  1  pulse; RUN -> IDLE.
- one_shot  in  1  1 = stop in DONE at the terminal count instead of wrapping/saturating.
- clear  in  1  synchronous clear of count, ovf and done.
- load  in  1  synchronous load of load_val.
- load_val  in  WIDTH  load value.
- count  out  WIDTH  current count.
- tc  out  1  combinational: (up_dn && count==MAX_VAL) || (!up_dn && count==0).
- wrap  out  1  registered one-cycle pulse when count wrapped.
- ovf  out  1  sticky; set on any wrap or saturate-blocked step.
- busy  out  1  state==RUN.
- done  out  1  state==DONE.

Behaviour:
- rst asserted, asynchronously: count=0, wrap=0, ovf=0, state=RUN if AUTO_START else IDLE (done=0).
- FSM states: IDLE, RUN, DONE.
  - IDLE: start -> RUN.
  - RUN: stop -> IDLE; stop has priority over a step in the same cycle (no step taken). One-shot terminal step (en && tc && one_shot) -> DONE.
  - DONE: start -> RUN; clear -> IDLE.
- Per-cycle count priority: clear > load > step > hold.
  - clear: count=0, ovf=0; state DONE -> IDLE, other states unchanged.
  - load: count = min(load_val, MAX_VAL); state unchanged; ovf unchanged; wrap=0.
  - step (RUN && en, no clear/load, no stop):
    - tc==0: count ±1.
    - tc==1 && one_shot: count held, state -> DONE, wrap=0, ovf unchanged.
    - tc==1 && !one_shot && !SATURATE: count wraps (MAX_VAL->0 up, 0->MAX_VAL down), wrap=1 next cycle, ovf=1.
    - tc==1 && !one_shot && SATURATE: count held, ovf=1, wrap=0.
- wrap is 0 in every cycle with no wrap; it never stays high two cycles unless wraps are consecutive (MAX_VAL==0 case: wraps every enabled cycle).
- Direction change mid-count takes effect on the next step; tc follows up_dn immediately.
- start while already in RUN: ignored. stop in IDLE/DONE: ignored.
- Latency: count, wrap, state update one clock after the control input is sampled; tc is zero-latency.
- Arithmetic is modulo MAX_VAL+1, never 2**WIDTH, when MAX_VAL < 2**WIDTH-1.
- Reset mid-operation aborts immediately; no residual pulses after release.

Decomposition:
- Shared package cnt_pkg: state enum (CNT_IDLE, CNT_RUN, CNT_DONE), helper function computing the next count given (count, up_dn, MAX_VAL).
- One natural sub-module: cnt_ctrl_fsm (start/stop/one_shot/tc -> state, busy, done); datapath stays in the top.

Test Plan:
- Legacy mode (WIDTH=4, defaults), rst pulse, en=1, up_dn=1 for 20 cycles -> count 0..15,0..3; wrap high exactly the cycle after 15->0; ovf=1 from then.
- MAX_VAL=9, up_dn=0, load load_val=3, run 5 cycles -> 3,2,1,0,9,8; wrap pulse after 0->9; load_val=12 -> count=9 (clamped).
- SATURATE=1, count up from 13 (WIDTH=4) -> 14,15,15,15; tc=1 at 15; wrap never asserted; ovf=1 after first blocked step; clear -> count=0, ovf=0.
- AUTO_START=0, one_shot=1, start at count=0, en=1 -> busy=1, count reaches 15, holds, done=1 and busy=0 the following cycle; start -> RUN again; clear while DONE -> IDLE, count=0.
- Simultaneous: clear+load+step in one cycle -> count=0; load+step -> load_val; stop+en at count=5 -> count stays 5, state IDLE.
- Assert rst asynchronously mid-count (between edges) at count=7 -> count=0 and wrap=0 immediately; state per AUTO_START on release.
